// File: rtl/sc_regbus_pkg.sv
// Shared types and constants for the register-bus decoder slice.
package sc_regbus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDerr,
    StTerr
  } ch_state_e;

  localparam int unsigned SC_REGBUS_TYP_W = 10;
  localparam int unsigned ADR_W           = 32;
  localparam int unsigned DAT_W           = 32;
  localparam int unsigned WENB_W          = 4;
  localparam int unsigned CNT_W           = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_regbus_dec_ch.sv
// One decoder channel: address decode, target latch, wait/error FSM.
// Timeout counter and error state only when SC_REGBUS_DECODER_TIMEOUT_EN is defined.
module sc_regbus_dec_ch
  import sc_regbus_pkg::*;
#(
  parameter int unsigned                   NSLV = 4,
  parameter logic [NSLV-1:0][ADR_W-1:0]    BASE = {NSLV{32'h0}},
  parameter logic [NSLV-1:0][ADR_W-1:0]    MASK = {NSLV{32'hFFFF_F000}}
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
  ,
  parameter int unsigned                   TMO_CYC = 255
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ADR_W-1:0] adr,
  input  logic             req,
  input  logic [NSLV-1:0]  slv_wat,
  input  logic [NSLV-1:0]  slv_err,
  output logic [NSLV-1:0]  sel,
  output logic             wat,
  output logic             err
);

  localparam int unsigned IW = idx_width(NSLV);

  ch_state_e       state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   hit_idx;
  logic            hit_any;
  logic [NSLV-1:0] sel_c;
  logic            wat_c, err_c;

  // Scan downwards so the lowest-index matching window wins.
  always_comb begin
    hit_idx = '0;
    hit_any = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((adr & MASK[i]) == (BASE[i] & MASK[i])) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_c   = '0;
    wat_c   = 1'b0;
    err_c   = 1'b0;
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit_any) begin
            sel_c[hit_idx] = 1'b1;
            wat_c          = slv_wat[hit_idx];
            err_c          = slv_err[hit_idx];
            if (slv_wat[hit_idx]) begin
              idx_d   = hit_idx;
              state_d = StBusy;
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end
          end else begin
            wat_c   = 1'b1;
            state_d = StDerr;
          end
        end
      end
      StBusy: begin
        // A withdrawn request abandons the access without a response.
        if (!req) begin
          state_d = StIdle;
        end else begin
          sel_c[idx_q] = 1'b1;
          wat_c        = slv_wat[idx_q];
          err_c        = slv_err[idx_q];
          if (!slv_wat[idx_q]) begin
            state_d = StIdle;
          end
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
          else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CNT_W'(TMO_CYC)) begin
              state_d = StTerr;
            end
          end
`endif
        end
      end
      StDerr, StTerr: begin
        err_c   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Everything is forced quiet while reset is held.
  assign sel = rstn ? sel_c : '0;
  assign wat = rstn & wat_c;
  assign err = rstn & err_c;

endmodule

// File: rtl/sc_regbus_decoder.sv
// Register-bus fan-out: one upstream master to NSLV slaves by address window.
// Optional slave timeout enabled by defining SC_REGBUS_DECODER_TIMEOUT_EN.
module sc_regbus_decoder
  import sc_regbus_pkg::*;
#(
  parameter int unsigned                NSLV    = 4,
  parameter logic [NSLV-1:0][ADR_W-1:0] BASE    = {NSLV{32'h0}},
  parameter logic [NSLV-1:0][ADR_W-1:0] MASK    = {NSLV{32'hFFFF_F000}},
  parameter int unsigned                TMO_CYC = 255
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [ADR_W-1:0]                      s_wadr,
  input  logic [SC_REGBUS_TYP_W-1:0]            s_wtyp,
  input  logic [WENB_W-1:0]                     s_wenb,
  input  logic [DAT_W-1:0]                      s_wdat,
  output logic                                  s_wwat,
  output logic                                  s_werr,
  input  logic [ADR_W-1:0]                      s_radr,
  input  logic [SC_REGBUS_TYP_W-1:0]            s_rtyp,
  input  logic                                  s_renb,
  output logic [DAT_W-1:0]                      s_rdat,
  output logic                                  s_rwat,
  output logic                                  s_rerr,
  output logic [NSLV-1:0][ADR_W-1:0]            m_wadr,
  output logic [NSLV-1:0][SC_REGBUS_TYP_W-1:0]  m_wtyp,
  output logic [NSLV-1:0][DAT_W-1:0]            m_wdat,
  output logic [NSLV-1:0][WENB_W-1:0]           m_wenb,
  input  logic [NSLV-1:0]                       m_wwat,
  input  logic [NSLV-1:0]                       m_werr,
  output logic [NSLV-1:0][ADR_W-1:0]            m_radr,
  output logic [NSLV-1:0][SC_REGBUS_TYP_W-1:0]  m_rtyp,
  output logic [NSLV-1:0]                       m_renb,
  input  logic [NSLV-1:0][DAT_W-1:0]            m_rdat,
  input  logic [NSLV-1:0]                       m_rwat,
  input  logic [NSLV-1:0]                       m_rerr
);

  if (NSLV < 1 || NSLV > 16) begin : g_bad_nslv
    $error("sc_regbus_decoder: NSLV must be 1..16");
  end
  if (TMO_CYC < 8 || TMO_CYC > 65535) begin : g_bad_tmo
    $error("sc_regbus_decoder: TMO_CYC must be 8..65535");
  end

  logic [NSLV-1:0] wsel, rsel;

  sc_regbus_dec_ch #(
    .NSLV    (NSLV),
    .BASE    (BASE),
    .MASK    (MASK)
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
    ,
    .TMO_CYC (TMO_CYC)
`endif
  ) u_wch (
    .clk     (clk),
    .rstn    (rstn),
    .adr     (s_wadr),
    .req     (|s_wenb),
    .slv_wat (m_wwat),
    .slv_err (m_werr),
    .sel     (wsel),
    .wat     (s_wwat),
    .err     (s_werr)
  );

  sc_regbus_dec_ch #(
    .NSLV    (NSLV),
    .BASE    (BASE),
    .MASK    (MASK)
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
    ,
    .TMO_CYC (TMO_CYC)
`endif
  ) u_rch (
    .clk     (clk),
    .rstn    (rstn),
    .adr     (s_radr),
    .req     (s_renb),
    .slv_wat (m_rwat),
    .slv_err (m_rerr),
    .sel     (rsel),
    .wat     (s_rwat),
    .err     (s_rerr)
  );

  always_comb begin
    s_rdat = '0;
    for (int i = 0; i < NSLV; i++) begin
      m_wadr[i] = s_wadr;
      m_wtyp[i] = s_wtyp;
      m_wdat[i] = s_wdat;
      m_wenb[i] = wsel[i] ? s_wenb : '0;
      m_radr[i] = s_radr;
      m_rtyp[i] = s_rtyp;
      m_renb[i] = rsel[i] & s_renb;
      if (rsel[i]) begin
        s_rdat = s_rdat | m_rdat[i];
      end
    end
  end

endmodule

// File: tb/tb_sc_regbus_decoder.sv
// Scoreboard bench for sc_regbus_decoder: drivers queue expectations, monitors check completions.
module tb_sc_regbus_decoder;

  localparam int NSLV = 4;

  typedef struct {
    logic        err;
    logic [31:0] rdat;
    int          waits;
    logic [15:0] menb;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [31:0]                  s_wadr, s_wdat, s_radr, s_rdat;
  logic [9:0]                   s_wtyp, s_rtyp;
  logic [3:0]                   s_wenb;
  logic                         s_renb, s_wwat, s_werr, s_rwat, s_rerr;
  logic [NSLV-1:0][31:0]        m_wadr, m_wdat, m_radr, m_rdat;
  logic [NSLV-1:0][9:0]         m_wtyp, m_rtyp;
  logic [NSLV-1:0][3:0]         m_wenb;
  logic [NSLV-1:0]              m_wwat, m_werr, m_renb, m_rwat, m_rerr;

  sc_regbus_decoder #(
    .NSLV    (NSLV),
    .BASE    ({32'h3000, 32'h2000, 32'h1000, 32'h0000}),
    .TMO_CYC (8)
  ) dut (
    .clk    (clk),    .rstn   (rstn),
    .s_wadr (s_wadr), .s_wtyp (s_wtyp), .s_wenb (s_wenb), .s_wdat (s_wdat),
    .s_wwat (s_wwat), .s_werr (s_werr),
    .s_radr (s_radr), .s_rtyp (s_rtyp), .s_renb (s_renb),
    .s_rdat (s_rdat), .s_rwat (s_rwat), .s_rerr (s_rerr),
    .m_wadr (m_wadr), .m_wtyp (m_wtyp), .m_wdat (m_wdat), .m_wenb (m_wenb),
    .m_wwat (m_wwat), .m_werr (m_werr),
    .m_radr (m_radr), .m_rtyp (m_rtyp), .m_renb (m_renb),
    .m_rdat (m_rdat), .m_rwat (m_rwat), .m_rerr (m_rerr)
  );

  // Slave models: each access waits cfg cycles while enabled, then completes.
  int w_cfg[NSLV], r_cfg[NSLV], w_cnt[NSLV], r_cnt[NSLV];

  always_comb begin
    for (int i = 0; i < NSLV; i++) begin
      m_wwat[i] = (w_cnt[i] < w_cfg[i]);
      m_rwat[i] = (r_cnt[i] < r_cfg[i]);
      m_rdat[i] = 32'hA5A5_0000 | 32'(i);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NSLV; i++) begin
      if (m_wenb[i] != 4'h0) w_cnt[i] <= (w_cnt[i] < w_cfg[i]) ? w_cnt[i] + 1 : 0;
      else                   w_cnt[i] <= 0;
      if (m_renb[i])         r_cnt[i] <= (r_cnt[i] < r_cfg[i]) ? r_cnt[i] + 1 : 0;
      else                   r_cnt[i] <= 0;
    end
  end

  exp_t wq[$], rq[$];
  int vectors = 0, miscompares = 0;
  int ww = 0, rw = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [31:0] rdat, input int waits,
                              input logic [15:0] menb);
    exp_t e;
    e.err = err; e.rdat = rdat; e.waits = waits; e.menb = menb;
    return e;
  endfunction

  // Monitor: counts upstream wait cycles and checks each completion against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      ww = 0;
      rw = 0;
    end else begin
      if (s_wenb != 4'h0) begin
        if (s_wwat) ww++;
        else begin
          if (wq.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
          else begin
            e = wq.pop_front();
            chk("w_waits", ww, e.waits);
            chk("w_err", {31'd0, s_werr}, {31'd0, e.err});
            chk("w_menb", {16'd0, m_wenb}, {16'd0, e.menb});
          end
          ww = 0;
        end
      end
      if (s_renb) begin
        if (s_rwat) rw++;
        else begin
          if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
          else begin
            e = rq.pop_front();
            chk("r_waits", rw, e.waits);
            chk("r_err", {31'd0, s_rerr}, {31'd0, e.err});
            chk("r_rdat", s_rdat, e.rdat);
            chk("r_menb", {28'd0, m_renb}, {16'd0, e.menb});
          end
          rw = 0;
        end
      end
    end
  end

  task automatic wr(input logic [31:0] adr, input logic [3:0] enb, input exp_t e);
    int n = 0;
    wq.push_back(e);
    @(posedge clk); #1;
    s_wadr = adr; s_wenb = enb; s_wdat = adr ^ 32'h5A5A_5A5A; s_wtyp = 10'h3;
    while (1) begin
      @(negedge clk);
      if (!s_wwat || n >= 100) break;
      n++;
    end
    if (s_wwat) chk("w_bound", 32'd1, 32'd0);
    @(posedge clk); #1;
    s_wenb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] alt, input exp_t e);
    int n = 0;
    rq.push_back(e);
    @(posedge clk); #1;
    s_radr = adr; s_renb = 1'b1; s_rtyp = 10'h1;
    while (1) begin
      @(negedge clk);
      if (!s_rwat || n >= 100) break;
      n++;
      @(posedge clk); #1;
      s_radr = alt;
    end
    if (s_rwat) chk("r_bound", 32'd1, 32'd0);
    @(posedge clk); #1;
    s_renb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NSLV; i++) begin
      w_cfg[i] = 0;
      r_cfg[i] = 0;
    end
    m_werr = '0; m_rerr = '0;
    s_wtyp = '0; s_rtyp = '0; s_wdat = '0;
    // Mapped requests held during reset must produce nothing downstream or upstream.
    rstn = 1'b0;
    s_wadr = 32'h2000; s_wenb = 4'hF; s_radr = 32'h1000; s_renb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wenb", {16'd0, m_wenb}, 32'd0);
    chk("rst_renb", {28'd0, m_renb}, 32'd0);
    chk("rst_rdat", s_rdat, 32'd0);
    chk("rst_wat", {30'd0, s_wwat, s_rwat}, 32'd0);
    @(posedge clk); #1;
    s_wenb = 4'h0; s_renb = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    wr(32'h2004, 4'hF, mk(1'b0, 32'h0, 0, 16'h0F00));
    wr(32'h8000, 4'hF, mk(1'b1, 32'h0, 1, 16'h0000));
    rd(32'h9000, 32'h9000, mk(1'b1, 32'h0, 1, 16'h0000));

    r_cfg[1] = 3;
    rd(32'h1010, 32'h9000, mk(1'b0, 32'hA5A5_0001, 3, 16'h0002));
    r_cfg[1] = 0;

    w_cfg[0] = 20;
`ifdef SC_REGBUS_DECODER_TIMEOUT_EN
    wr(32'h0010, 4'h3, mk(1'b1, 32'h0, 9, 16'h0000));
`else
    wr(32'h0010, 4'h3, mk(1'b0, 32'h0, 20, 16'h0003));
`endif

    w_cfg[0] = 2;
    fork
      wr(32'h0008, 4'hC, mk(1'b0, 32'h0, 2, 16'h000C));
      rd(32'h3000, 32'h3000, mk(1'b0, 32'hA5A5_0003, 0, 16'h0008));
    join
    w_cfg[0] = 0;

    m_werr[3] = 1'b1;
    wr(32'h3FFC, 4'h5, mk(1'b1, 32'h0, 0, 16'h5000));
    m_werr[3] = 1'b0;

    // Reset while a read is waiting on slave 1.
    r_cfg[1] = 5;
    @(posedge clk); #1;
    s_radr = 32'h1000; s_renb = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_renb", {28'd0, m_renb}, 32'd0);
    chk("mid_rst_rwat", {31'd0, s_rwat}, 32'd0);
    chk("mid_rst_rerr", {31'd0, s_rerr}, 32'd0);
    chk("mid_rst_rdat", s_rdat, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; s_renb = 1'b0; r_cfg[1] = 0;
    rd(32'h1000, 32'h1000, mk(1'b0, 32'hA5A5_0001, 0, 16'h0002));

    repeat (3) @(posedge clk);
    chk("wq_drained", wq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sc_regbus_decoder.md
# sc_regbus_decoder

Parametrised register-bus fan-out: one upstream register-bus master (bus IP side) is routed to NSLV downstream register slaves by address window. Write and read channels are decoded independently. Each channel latches its target for the duration of a waited access and returns an error on unmapped addresses and, optionally, on slave timeout. It sits between a bus bridge and the per-peripheral register files.

## Interface
- NSLV, 4: number of downstream slaves (1..16)
- BASE, {NSLV{32'h0}}: packed array of window base addresses, slave i at BASE[i]
- MASK, {NSLV{32'hFFFF_F000}}: address bits compared; hit when (ADR & MASK[i]) == (BASE[i] & MASK[i])
- TMO_CYC, 255: consecutive wait cycles before timeout (8..65535)
- CLK  in  1  clock
- RSTN  in  1  synchronous active-low reset
- S_WADR/S_WTYP/S_WENB/S_WDAT  in  32/10/4/32  upstream write request
- S_WWAT, S_WERR  out  1 each  upstream write wait/error
- S_RADR/S_RTYP/S_RENB  in  32/10/1  upstream read request
- S_RDAT  out  32; S_RWAT, S_RERR  out  1 each  upstream read response
- M_WADR/M_WTYP/M_WDAT  out  [NSLV] x 32/10/32  broadcast to all slaves
- M_WENB  out  [NSLV] x 4  per-slave write enable, zero for unselected slaves
- M_WWAT, M_WERR  in  [NSLV] x 1
- M_RADR/M_RTYP  out  [NSLV] x 32/10; M_RENB  out  [NSLV] x 1
- M_RDAT  in  [NSLV] x 32; M_RWAT, M_RERR  in  [NSLV] x 1

## Operation
- Access protocol: request active when WENB != 0 (write) / RENB = 1 (read); master holds request stable while WWAT/RWAT = 1; access completes in the first request cycle with WAT = 0; ERR and RDAT valid only in that cycle.
- Decode: lowest-index hitting window wins on overlap; no hit = unmapped.
- Per-channel FSM (identical for W and R):
  - IDLE: request to slave i -> enable forwarded combinationally; slave WAT=0 -> completes same cycle, stay IDLE; WAT=1 -> latch i, go BUSY. Unmapped request -> no slave enabled, WAT=1, go DERR.
  - BUSY: enable routed to latched slave regardless of address; response muxed from latched slave; slave WAT=0 -> complete, IDLE. Counter reaches TMO_CYC -> go TERR.
  - DERR / TERR: all slave enables 0; upstream WAT=0, ERR=1, RDAT=0 for one cycle; IDLE next.
- Request withdrawn by master in BUSY (protocol violation): return to IDLE, no response.
- Write and read channels are fully independent; concurrent accesses to same or different slaves both proceed.
- Upstream WERR/RERR/RDAT in IDLE/BUSY are the selected slave's values, zero when no slave selected.

## Timing
- Reset (RSTN=0 at CLK edge): FSMs IDLE, counters 0, latched index 0; while RSTN=0 all M_WENB/M_RENB = 0, S_WWAT/S_RWAT/S_WERR/S_RERR = 0, S_RDAT = 0. Reset mid-access aborts it with no response.
- Zero-wait mapped access: 0 added latency (combinational path).
- Unmapped access: exactly 1 wait cycle, completes in cycle 2 with ERR=1.
- Wait counter: cleared on entry to BUSY (counts first wait cycle as 1), increments each BUSY cycle with WAT=1, saturating; TERR entered the cycle after count == TMO_CYC, so upstream sees TMO_CYC+1 wait cycles, then error cycle.
- Slave WAT falling in the same cycle counter hits TMO_CYC: slave completion wins.

## Configuration
- SC_REGBUS_DECODER_TIMEOUT_EN defined: counter and TERR state built; TMO_CYC effective.
- Undefined: no counter, TERR unreachable, BUSY waits indefinitely; TMO_CYC ignored.

## Structure
- sc_regbus_pkg: channel state enum (IDLE, BUSY, DERR, TERR), SC_REGBUS_TYP_W=10, address/data width constants, slave-index width function.
- Sub-module sc_regbus_dec_ch: one channel FSM + counter + decode, instantiated twice (write, read); top does only signal bundling and muxing.

## Test plan
- NSLV=4, BASE[2]=32'h2000: write 0x2004 WENB=4'hF, slave 2 WWAT=0 -> M_WENB[2]=4'hF only, S_WWAT=0 same cycle.
- Read 0x9000 (unmapped) -> S_RWAT=1 cycle 1, cycle 2 S_RWAT=0, S_RERR=1, S_RDAT=0, no M_RENB asserted.
- Slave 1 read holds RWAT 3 cycles, RDAT=32'hA5A5_0001 -> 3 upstream waits, completion with that data; address changed mid-wait still routed to slave 1.
- Timeout EN, TMO_CYC=8, slave 0 WWAT stuck 1 -> 9 wait cycles, then S_WERR=1 S_WWAT=0, M_WENB[0]=0 from error cycle.
- Concurrent write to slave 0 (2 waits) and read from slave 3 (0 waits) -> both complete independently, correct data/enables.
- RSTN low during BUSY -> next cycle all enables 0, upstream outputs 0; after release, fresh access completes normally.
